// File: rtl/mmio_pkg.sv
// Shared constants for the timer/PWM MMIO bank.
// Region base, register word offsets, CTRL bits, load/store size codes.
package mmio_pkg;

  localparam logic [23:0] REGION = 24'hFFFFFF;

  localparam logic [5:0] OFF_MICROS = 6'h00;
  localparam logic [5:0] OFF_MILLIS = 6'h01;
  localparam logic [5:0] OFF_CMP    = 6'h02;
  localparam logic [5:0] OFF_PERIOD = 6'h03;
  localparam logic [5:0] OFF_CTRL   = 6'h04;
  localparam logic [5:0] OFF_STATUS = 6'h05;
  localparam logic [5:0] OFF_PWM    = 6'h10;

  localparam int CTRL_IRQ_EN   = 0;
  localparam int CTRL_PERIODIC = 1;
  localparam int CTRL_CMP_EN   = 2;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  function automatic logic [31:0] merge(
    input logic [31:0] old,
    input logic [3:0]  be,
    input logic [31:0] wl
  );
    logic [31:0] r;
    for (int i = 0; i < 4; i++)
      r[8*i +: 8] = be[i] ? wl[8*i +: 8] : old[8*i +: 8];
    return r;
  endfunction

endpackage

// File: rtl/tick_divider.sv
// One-cycle tick every DIV clocks.
// DIV of 1 ticks on every clock.
module tick_divider #(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic reset,
  output logic tick
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(DIV - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      cnt <= '0;
    else if (tick)
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/mmio_timer_pwm.sv
// Memory-mapped bank: micro/milli counters, compare timer, PWM.
// Reads are registered as words, then sized per funct3.
module mmio_timer_pwm
  import mmio_pkg::*;
#(
  parameter int CLK_HZ  = 12_000_000,
  parameter int NUM_PWM = 4,
  parameter int PWM_DIV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               write_mem,
  input  logic [2:0]         funct3,
  input  logic [31:0]        write_address,
  input  logic [31:0]        write_data,
  input  logic [31:0]        read_address,
  output logic [31:0]        read_data,
  output logic [NUM_PWM-1:0] pwm_out,
  output logic               irq
);

  logic        us_tick;
  logic        pwm_step;
  logic [31:0] micros;
  logic [31:0] micros_nx;
  logic [31:0] millis;
  logic [9:0]  ms_sub;
  logic [31:0] cmp;
  logic [31:0] period;
  logic        irq_en;
  logic        periodic;
  logic        cmp_en;
  logic        match_flag;
  logic        match;
  logic [7:0]  pwm_cnt;
  logic [7:0]  duty [NUM_PWM];
  logic [31:0] rd_q;
  logic [31:0] rword;
  logic [3:0]  be;
  logic [31:0] wl;
  logic        w_hit;
  logic        r_hit;
  logic [5:0]  w_off;
  logic [5:0]  r_off;
  logic        w1c;
  logic        wr_ctrl;
  logic [7:0]  rb;
  logic [15:0] rh;

  tick_divider #(.DIV(CLK_HZ / 1_000_000)) u_us (
    .clk   (clk),
    .reset (reset),
    .tick  (us_tick)
  );

  tick_divider #(.DIV(PWM_DIV)) u_pwm (
    .clk   (clk),
    .reset (reset),
    .tick  (pwm_step)
  );

  assign w_hit = write_mem && (write_address[31:8] == REGION);
  assign r_hit = (read_address[31:8] == REGION);
  assign w_off = write_address[7:2];
  assign r_off = read_address[7:2];

  // Store data is right-aligned; replicate it across lanes, mask by be.
  always_comb begin
    be = '0;
    wl = write_data;
    unique case (funct3)
      F3_B: begin
        be = 4'b0001 << write_address[1:0];
        wl = {4{write_data[7:0]}};
      end
      F3_H: begin
        be = write_address[1] ? 4'b1100 : 4'b0011;
        wl = {2{write_data[15:0]}};
      end
      F3_W:    be = 4'b1111;
      default: be = '0;
    endcase
  end

  assign w1c     = w_hit && (w_off == OFF_STATUS) && be[0] && wl[0];
  assign wr_ctrl = w_hit && (w_off == OFF_CTRL) && be[0];

  assign micros_nx = micros + 32'd1;
  assign match     = cmp_en && us_tick && (micros_nx == cmp);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      micros  <= '0;
      millis  <= '0;
      ms_sub  <= '0;
      pwm_cnt <= '0;
    end else begin
      if (us_tick) begin
        micros <= micros_nx;
        if (ms_sub == 10'd999) begin
          ms_sub <= '0;
          millis <= millis + 32'd1;
        end else begin
          ms_sub <= ms_sub + 10'd1;
        end
      end
      if (pwm_step)
        pwm_cnt <= pwm_cnt + 8'd1;
    end
  end

  // Bus writes are applied last so they win over match side effects.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmp        <= '0;
      period     <= '0;
      irq_en     <= 1'b0;
      periodic   <= 1'b0;
      cmp_en     <= 1'b0;
      match_flag <= 1'b0;
    end else begin
      match_flag <= match | (match_flag & ~w1c);
      if (match) begin
        if (periodic)
          cmp <= cmp + period;
        else
          cmp_en <= 1'b0;
      end
      if (w_hit && (w_off == OFF_CMP))
        cmp <= merge(cmp, be, wl);
      if (w_hit && (w_off == OFF_PERIOD))
        period <= merge(period, be, wl);
      if (wr_ctrl) begin
        irq_en   <= wl[CTRL_IRQ_EN];
        periodic <= wl[CTRL_PERIODIC];
        cmp_en   <= wl[CTRL_CMP_EN];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int c = 0; c < NUM_PWM; c++)
        duty[c] <= '0;
    end else begin
      for (int c = 0; c < NUM_PWM; c++)
        if (w_hit && (w_off == OFF_PWM + 6'(c / 4)) && be[c % 4])
          duty[c] <= wl[8*(c % 4) +: 8];
    end
  end

  always_comb begin
    rword = '0;
    if (r_hit) begin
      unique case (r_off)
        OFF_MICROS: rword = micros;
        OFF_MILLIS: rword = millis;
        OFF_CMP:    rword = cmp;
        OFF_PERIOD: rword = period;
        OFF_CTRL:   rword = {29'b0, cmp_en, periodic, irq_en};
        OFF_STATUS: rword = {31'b0, match_flag};
        default:    rword = '0;
      endcase
      for (int c = 0; c < NUM_PWM; c++)
        if (r_off == OFF_PWM + 6'(c / 4))
          rword[8*(c % 4) +: 8] = duty[c];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      rd_q <= '0;
    else
      rd_q <= rword;
  end

  assign rb = rd_q[{read_address[1:0], 3'b000} +: 8];
  assign rh = read_address[1] ? rd_q[31:16] : rd_q[15:0];

  always_comb begin
    unique case (funct3)
      F3_B:    read_data = {{24{rb[7]}}, rb};
      F3_BU:   read_data = {24'b0, rb};
      F3_H:    read_data = {{16{rh[15]}}, rh};
      F3_HU:   read_data = {16'b0, rh};
      default: read_data = rd_q;
    endcase
  end

  always_comb begin
    for (int c = 0; c < NUM_PWM; c++)
      pwm_out[c] = (pwm_cnt < duty[c]);
  end

  assign irq = match_flag & irq_en;

endmodule

// File: tb/tb_mmio_timer_pwm.sv
// Scoreboarded bench for mmio_timer_pwm.
// Inputs change on falling edges; outputs sampled there too.
module tb_mmio_timer_pwm;

  localparam logic [31:0] A_MICROS = 32'hFFFFFF00;
  localparam logic [31:0] A_MILLIS = 32'hFFFFFF04;
  localparam logic [31:0] A_CMP    = 32'hFFFFFF08;
  localparam logic [31:0] A_PER    = 32'hFFFFFF0C;
  localparam logic [31:0] A_CTRL   = 32'hFFFFFF10;
  localparam logic [31:0] A_STAT   = 32'hFFFFFF14;
  localparam logic [31:0] A_PWM0   = 32'hFFFFFF40;
  localparam logic [31:0] A_PWM1   = 32'hFFFFFF44;

  localparam logic [2:0] SB  = 3'b000;
  localparam logic [2:0] SH  = 3'b001;
  localparam logic [2:0] SW  = 3'b010;
  localparam logic [2:0] LBU = 3'b100;
  localparam logic [2:0] LHU = 3'b101;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        write_mem = 1'b0;
  logic [2:0]  funct3 = 3'b010;
  logic [31:0] write_address = '0;
  logic [31:0] write_data = '0;
  logic [31:0] read_address = '0;
  logic [31:0] read_data;
  logic [5:0]  pwm_out;
  logic        irq;

  int checks = 0;
  int errors = 0;
  int cyc;
  logic [31:0] sbq [$];

  mmio_timer_pwm #(
    .CLK_HZ  (12_000_000),
    .NUM_PWM (6),
    .PWM_DIV (2)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .write_mem     (write_mem),
    .funct3        (funct3),
    .write_address (write_address),
    .write_data    (write_data),
    .read_address  (read_address),
    .read_data     (read_data),
    .pwm_out       (pwm_out),
    .irq           (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk or posedge reset)
    if (reset) cyc <= 0;
    else cyc <= cyc + 1;

  initial begin
    #3_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic do_reset();
    reset = 1'b1;
    write_mem = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    sbq.delete();
  endtask

  task automatic wr(input logic [31:0] a, input logic [2:0] f,
                    input logic [31:0] d);
    write_mem = 1'b1;
    write_address = a;
    write_data = d;
    funct3 = f;
    @(negedge clk);
    write_mem = 1'b0;
  endtask

  task automatic issue(input logic [31:0] a, input logic [2:0] f,
                       input logic [31:0] e);
    read_address = a;
    funct3 = f;
    sbq.push_back(e);
  endtask

  task automatic test_reset();
    logic [31:0] e;
    logic [31:0] ad [3] = '{A_MICROS, A_CTRL, A_CMP};
    int n = 0;
    do_reset();
    wr(A_PWM0, SB, 32'h80);
    wr(A_CMP, SW, 32'd5);
    wr(A_CTRL, SW, 32'h5);
    while (!irq && n < 200) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_irq got %b want 1", irq);
    end
    checks++;
    if (pwm_out[0] !== 1'b1) begin
      errors++;
      $display("FAIL pre_reset_pwm got %b want 1", pwm_out[0]);
    end
    issue(A_CMP, SW, 32'd5);
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (read_data !== e) begin
      errors++;
      $display("FAIL pre_reset_cmp got %h want %h", read_data, e);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({read_data, pwm_out, irq} !== 39'd0) begin
      errors++;
      $display("FAIL reset_outputs got %h %b %b want 0",
               read_data, pwm_out, irq);
    end
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      issue(ad[i], SW, 32'd0);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (read_data !== e) begin
        errors++;
        $display("FAIL reset_read%0d got %h want %h", i, read_data, e);
      end
    end
  endtask

  task automatic test_counters();
    logic [31:0] e;
    logic [31:0] ad [4] = '{A_MICROS, A_MILLIS, A_MICROS, A_MICROS};
    logic [2:0]  fs [4] = '{SW, SW, LBU, SH};
    logic [31:0] ex [4] = '{32'd1000, 32'd1, 32'hE8, 32'h3E8};
    do_reset();
    repeat (12000) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      issue(ad[i], fs[i], ex[i]);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (read_data !== e) begin
        errors++;
        $display("FAIL counters%0d got %h want %h", i, read_data, e);
      end
    end
  endtask

  task automatic test_oneshot();
    logic [31:0] e;
    logic [31:0] ad [4] = '{A_MICROS, A_CTRL, A_STAT, A_CMP};
    logic [31:0] ex [4] = '{32'd50, 32'h1, 32'h1, 32'd50};
    int n = 0;
    do_reset();
    wr(A_CMP, SW, 32'd50);
    wr(A_CTRL, SW, 32'h5);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_early got %b want 0", irq);
    end
    while (!irq && n < 1000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL oneshot_irq got %b want 1", irq);
    end
    for (int i = 0; i < 4; i++) begin
      issue(ad[i], SW, ex[i]);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (read_data !== e) begin
        errors++;
        $display("FAIL oneshot_read%0d got %h want %h", i, read_data, e);
      end
    end
    wr(A_STAT, SB, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_w1c got %b want 0", irq);
    end
    repeat (700) @(negedge clk);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL oneshot_rearm got %b want 0", irq);
    end
  endtask

  task automatic test_periodic();
    logic [31:0] e;
    int n = 0;
    do_reset();
    wr(A_CMP, SW, 32'd10);
    wr(A_PER, SW, 32'd10);
    wr(A_CTRL, SW, 32'h7);
    while (!irq && n < 500) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL periodic_irq got %b want 1", irq);
    end
    issue(A_CMP, SW, 32'd20);
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (read_data !== e) begin
      errors++;
      $display("FAIL periodic_cmp20 got %h want %h", read_data, e);
    end
    wr(A_STAT, SW, 32'h1);
    checks++;
    if (irq !== 1'b0) begin
      errors++;
      $display("FAIL periodic_clear got %b want 0", irq);
    end
    n = 0;
    while (cyc != 239 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (cyc != 239) begin
      errors++;
      $display("FAIL periodic_align got %0d want 239", cyc);
    end
    wr(A_STAT, SW, 32'h1);
    checks++;
    if (irq !== 1'b1) begin
      errors++;
      $display("FAIL periodic_set_wins got %b want 1", irq);
    end
    issue(A_CMP, SW, 32'd30);
    @(negedge clk);
    e = sbq.pop_front();
    checks++;
    if (read_data !== e) begin
      errors++;
      $display("FAIL periodic_cmp30 got %h want %h", read_data, e);
    end
  endtask

  task automatic test_pwm();
    logic [31:0] e;
    int hi [6];
    int wn [6] = '{510, 0, 0, 0, 0, 256};
    logic [31:0] ad [6] = '{32'hFFFFFF45, 32'hFFFFFF45, 32'hFFFFFF46,
                            A_PWM1, 32'hFFFFFF48, A_PWM0};
    logic [2:0]  fs [6] = '{SB, LBU, LBU, SW, SW, SW};
    logic [31:0] ex [6] = '{32'hFFFFFF80, 32'h80, 32'h0,
                            32'h8000, 32'h0, 32'hFF};
    do_reset();
    wr(32'hFFFFFF45, SB, 32'h80);
    wr(A_PWM0, SW, 32'h0000_00FF);
    for (int c = 0; c < 6; c++) hi[c] = 0;
    for (int i = 0; i < 512; i++) begin
      @(negedge clk);
      for (int c = 0; c < 6; c++) if (pwm_out[c] === 1'b1) hi[c]++;
    end
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (hi[c] != wn[c]) begin
        errors++;
        $display("FAIL pwm_ch%0d high %0d want %0d", c, hi[c], wn[c]);
      end
    end
    for (int i = 0; i < 6; i++) begin
      issue(ad[i], fs[i], ex[i]);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (read_data !== e) begin
        errors++;
        $display("FAIL pwm_read%0d got %h want %h", i, read_data, e);
      end
    end
  endtask

  task automatic test_ignored();
    logic [31:0] e;
    logic [31:0] ad [6] = '{A_CMP, 32'hFFFFFE08, A_CMP,
                            A_CMP + 2, A_CMP + 2, A_CMP + 1};
    logic [2:0]  fs [6] = '{SW, SW, SW, SH, LHU, SB};
    logic [31:0] ex [6] = '{32'h12345678, 32'h0, 32'hABCD5678,
                            32'hFFFFABCD, 32'h0000ABCD, 32'h56};
    do_reset();
    wr(A_CMP, SW, 32'h12345678);
    wr(32'hFFFFFEFC, SW, 32'hDEADBEEF);
    wr(32'hFFFFFE08, SW, 32'hDEADBEEF);
    wr(A_CMP, 3'b011, 32'hDEADBEEF);
    wr(A_CMP, 3'b111, 32'hDEADBEEF);
    for (int i = 0; i < 6; i++) begin
      if (i == 2) wr(A_CMP + 2, SH, 32'h0000ABCD);
      issue(ad[i], fs[i], ex[i]);
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (read_data !== e) begin
        errors++;
        $display("FAIL ignored_read%0d got %h want %h", i, read_data, e);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] e;
    logic [31:0] ad [6] = '{A_CMP, A_PER, A_CTRL, A_STAT,
                            A_PWM1, 32'h0000_0008};
    logic [31:0] ex [6] = '{32'h77, 32'hA5A50003, 32'h2, 32'h0,
                            32'h0, 32'h0};
    do_reset();
    wr(A_PER, SW, 32'hA5A50003);
    wr(A_CTRL, SW, 32'hFFFFFFFA);
    write_mem = 1'b1;
    write_address = A_CMP;
    write_data = 32'h77;
    issue(A_CMP, SW, 32'h0);
    @(negedge clk);
    write_mem = 1'b0;
    e = sbq.pop_front();
    checks++;
    if (read_data !== e) begin
      errors++;
      $display("FAIL same_cycle_old got %h want %h", read_data, e);
    end
    issue(ad[0], SW, ex[0]);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      e = sbq.pop_front();
      checks++;
      if (read_data !== e) begin
        errors++;
        $display("FAIL b2b_read%0d got %h want %h", i, read_data, e);
      end
      if (i + 1 < 6) issue(ad[i+1], SW, ex[i+1]);
    end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_counters();
    test_oneshot();
    test_periodic();
    test_pwm();
    test_ignored();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
